// File: rtl/uart_cmd_responder_pkg.sv
// uart_cmd_responder shared types and constants
// state encoding, frame bytes, bus widths
package uart_cmd_responder_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_BUS_WR,
    ST_BUS_RD,
    ST_RESP,
    ST_NAK
  } state_t;

endpackage

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte frames in, register bus
// transfers out, ack/data bytes back to the uart tx
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_ena,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic [1:0]        in_error,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic [ADDR_W-1:0] bus_address,
  output logic              bus_write,
  output logic              bus_read,
  output logic [DATA_W-1:0] bus_writedata,
  input  logic [DATA_W-1:0] bus_readdata,
  input  logic              bus_waitrequest,
  output logic              busy
);

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t          state, state_n;
  logic            is_wr;
  logic [1:0]      wcnt;
  logic [TW-1:0]   tcnt;
  logic [39:0]     rsp_sr;
  logic [2:0]      rsp_cnt;
  logic            accept, bad, rx_wait, tmo;
  logic            bus_ack, tx_fire;

  assign in_ready  = (state == ST_IDLE) ||
                     (state == ST_ADDR) ||
                     (state == ST_WDATA);
  assign out_valid = (state == ST_RESP) ||
                     (state == ST_NAK);
  assign out_data  = rsp_sr[39:32];
  assign bus_write = (state == ST_BUS_WR);
  assign bus_read  = (state == ST_BUS_RD);
  assign busy      = (state != ST_IDLE);

  assign accept  = clk_ena & in_valid & in_ready;
  assign bad     = |in_error;
  assign rx_wait = (state == ST_ADDR) ||
                   (state == ST_WDATA);
  assign tmo     = (TIMEOUT_CYCLES != 0) &&
                   rx_wait && (tcnt == T_LAST);
  assign bus_ack = clk_ena & ~bus_waitrequest;
  assign tx_fire = clk_ena & out_valid & out_ready;

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     state <= ST_IDLE;
    else if (clk_ena) state <= state_n;
  end

  // next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (bad)
            state_n = ST_NAK;
          else if (in_data == CMD_WRITE ||
                   in_data == CMD_READ)
            state_n = ST_ADDR;
          else
            state_n = ST_NAK;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          if (bad)        state_n = ST_NAK;
          else if (is_wr) state_n = ST_WDATA;
          else            state_n = ST_BUS_RD;
        end else if (tmo) begin
          state_n = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (accept) begin
          if (bad)              state_n = ST_NAK;
          else if (wcnt == 2'd3) state_n = ST_BUS_WR;
        end else if (tmo) begin
          state_n = ST_IDLE;
        end
      end
      ST_BUS_WR,
      ST_BUS_RD: begin
        if (bus_ack) state_n = ST_RESP;
      end
      ST_RESP: begin
        if (tx_fire && rsp_cnt == 3'd1)
          state_n = ST_IDLE;
      end
      ST_NAK: begin
        if (tx_fire) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // frame capture, timeout counter, response shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_wr         <= 1'b0;
      wcnt          <= 2'd0;
      tcnt          <= '0;
      bus_address   <= '0;
      bus_writedata <= '0;
      rsp_sr        <= '0;
      rsp_cnt       <= 3'd0;
    end else if (clk_ena) begin
      if (accept && !bad && state == ST_IDLE)
        is_wr <= (in_data == CMD_WRITE);
      if (accept && !bad && state == ST_ADDR) begin
        bus_address <= in_data;
        wcnt        <= 2'd0;
      end
      if (accept && !bad && state == ST_WDATA) begin
        bus_writedata <= {bus_writedata[23:0], in_data};
        wcnt          <= wcnt + 2'd1;
      end
      if (accept || !rx_wait) tcnt <= '0;
      else if (!tmo)          tcnt <= tcnt + 1'b1;
      if (state_n == ST_NAK && state != ST_NAK) begin
        rsp_sr  <= {RSP_NAK, 32'h0};
        rsp_cnt <= 3'd1;
      end else if (state_n == ST_RESP &&
                   state != ST_RESP) begin
        rsp_sr  <= {RSP_ACK,
                    is_wr ? 32'h0 : bus_readdata};
        rsp_cnt <= is_wr ? 3'd1 : 3'd5;
      end else if (tx_fire) begin
        rsp_sr  <= {rsp_sr[31:0], 8'h00};
        rsp_cnt <= rsp_cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: directed frames with a
// scoreboard of expected bus transfers and bytes
module tb_uart_cmd_responder;
  import uart_cmd_responder_pkg::*;

  typedef struct packed {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
  } bus_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_ena = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic [1:0]  in_error = 2'b00;
  logic        out_ready = 1'b1;
  logic [31:0] bus_readdata = 32'h0;
  logic        bus_waitrequest;
  logic        in_ready, out_valid, busy;
  logic [7:0]  out_data, bus_address;
  logic        bus_write, bus_read;
  logic [31:0] bus_writedata;

  int tests = 0;
  int fails = 0;
  int wait_cfg = 0;
  int txn = 0;
  int hold = 0;
  int rx_cnt = 0;
  bit ena_div = 1'b0;
  logic [1:0] phase = 2'd0;
  logic stalled = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] mon_e;
  bus_t mon_b;
  logic [7:0] exp_q[$];
  bus_t bus_q[$];

  uart_cmd_responder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .clk_ena(clk_ena),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_error(in_error),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .bus_address(bus_address),
    .bus_write(bus_write),
    .bus_read(bus_read),
    .bus_writedata(bus_writedata),
    .bus_readdata(bus_readdata),
    .bus_waitrequest(bus_waitrequest),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign bus_waitrequest =
    (bus_write || bus_read) && (txn < wait_cfg);

  task automatic chk(input string tag,
                     input logic [39:0] obs,
                     input logic [39:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // clock enable pattern: always on, or 1-in-4
  always begin
    @(posedge clk);
    #1;
    phase = phase + 2'd1;
    clk_ena = !ena_div || (phase == 2'd0);
  end

  // slave wait-state generator
  always @(posedge clk) begin
    if (!reset_n)
      txn <= 0;
    else if (clk_ena && (bus_write || bus_read))
      txn <= bus_waitrequest ? txn + 1 : 0;
  end

  // output and bus monitors
  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 0;
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid)
        chk("out_stable", out_data, prev_data);
      stalled = out_valid && !(out_ready && clk_ena);
      prev_data = out_data;
      if (clk_ena && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("out_unexp", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_byte", out_data, mon_e);
        end
        rx_cnt++;
      end
      if (clk_ena && (bus_write || bus_read)) begin
        hold++;
        if (!bus_waitrequest) begin
          if (bus_q.size() == 0) begin
            chk("bus_unexp", {bus_write, bus_read}, 0);
          end else begin
            mon_b = bus_q.pop_front();
            chk("bus_kind", {bus_write, bus_read},
                {mon_b.wr, ~mon_b.wr});
            chk("bus_addr", bus_address, mon_b.a);
            if (mon_b.wr)
              chk("bus_wdata", bus_writedata, mon_b.d);
            chk("bus_hold", hold, wait_cfg + 1);
          end
          hold = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b,
                      input logic [1:0] e);
    in_valid = 1'b1;
    in_data  = b;
    in_error = e;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (clk_ena && in_ready) break;
      if (i == 999) chk("send_tmo", in_ready, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_error = 2'b00;
  endtask

  task automatic write_frame(input logic [7:0] a,
                             input logic [31:0] d);
    bus_q.push_back(bus_t'({1'b1, a, d}));
    exp_q.push_back(RSP_ACK);
    send(CMD_WRITE, 2'b00);
    send(a, 2'b00);
    send(d[31:24], 2'b00);
    send(d[23:16], 2'b00);
    send(d[15:8], 2'b00);
    send(d[7:0], 2'b00);
  endtask

  task automatic read_frame(input logic [7:0] a,
                            input logic [31:0] d);
    bus_readdata = d;
    bus_q.push_back(bus_t'({1'b0, a, 32'h0}));
    exp_q.push_back(RSP_ACK);
    exp_q.push_back(d[31:24]);
    exp_q.push_back(d[23:16]);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    send(CMD_READ, 2'b00);
    send(a, 2'b00);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!busy && exp_q.size() == 0 &&
          bus_q.size() == 0) break;
    end
    chk(tag, {busy, exp_q.size() != 0,
              bus_q.size() != 0}, 0);
  endtask

  task automatic chk_reset_outs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_bus_write", bus_write, 0);
    chk("rst_bus_read", bus_read, 0);
    chk("rst_bus_addr", bus_address, 8'h00);
    chk("rst_bus_wdata", bus_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // write, no wait: latency around the strobe
    write_frame(8'h10, 32'hDEADBEEF);
    chk("wr_strobe", bus_write, 1);
    chk("wr_early_valid", out_valid, 0);
    @(posedge clk);
    #1;
    chk("wr_strobe_drop", bus_write, 0);
    chk("wr_ack_valid", out_valid, 1);
    chk("wr_ack_data", out_data, RSP_ACK);
    wait_done("wr_done");

    // read with 3 wait states and a 5-cycle stall
    wait_cfg = 3;
    base = rx_cnt;
    read_frame(8'h20, 32'h12345678);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rx_cnt >= base + 2) break;
    end
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done("rd_done");
    wait_cfg = 0;

    // bad command byte
    exp_q.push_back(RSP_NAK);
    send(8'h41, 2'b00);
    chk("nak_valid", out_valid, 1);
    chk("nak_data", out_data, RSP_NAK);
    wait_done("nak_done");

    // framing error mid-frame
    exp_q.push_back(RSP_NAK);
    send(CMD_WRITE, 2'b00);
    send(8'h10, 2'b00);
    send(8'hAA, 2'b10);
    wait_done("err_done");

    // inter-byte timeout
    send(CMD_WRITE, 2'b00);
    send(8'h10, 2'b00);
    n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (!busy) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", n, 100);
    read_frame(8'h10, 32'hCAFEF00D);
    wait_done("tmo_next_rd");

    // same traffic with a 1-in-4 clock enable
    ena_div = 1'b1;
    write_frame(8'h10, 32'hDEADBEEF);
    wait_done("ena_wr_done");
    read_frame(8'h20, 32'h12345678);
    wait_done("ena_rd_done");
    ena_div = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // reset during the second byte of a read reply
    base = rx_cnt;
    read_frame(8'h30, 32'hA55A3CC3);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (rx_cnt >= base + 1) break;
    end
    chk("mid_valid", out_valid, 1);
    chk("mid_data", out_data, 8'hA5);
    reset_n = 1'b0;
    #1;
    chk_reset_outs();
    exp_q.delete();
    bus_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", out_valid, 0);
    chk("end_queues",
        {exp_q.size() != 0, bus_q.size() != 0}, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
